// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: occupancy states and small decode helpers
// reused by every elastic stage in the processor pipeline.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int unsigned STAGE_DEPTH = 2;
  localparam int unsigned SLOT_MAIN   = 0;
  localparam int unsigned SLOT_SKID   = 1;

  function automatic logic state_has_entry(input stage_state_e s);
    return (s != ST_EMPTY);
  endfunction

  function automatic logic state_has_room(input stage_state_e s);
    return (s != ST_FULL);
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with synchronous active-high reset to a parametrised value
// and a load enable; reset wins over load.
module pipe_data_reg #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             i_srst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_q <= RESET_VALUE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline stage: registered valid/ready handshake, flush to a
// bubble value, and a saturating count of downstream stall cycles.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_state_e r_state;
  stage_state_e w_state_next;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_accept;
  logic             w_deliver;
  logic             w_main_from_skid;
  logic             w_clear;
  logic             w_load [STAGE_DEPTH];
  logic [WIDTH-1:0] w_d    [STAGE_DEPTH];
  logic [WIDTH-1:0] w_q    [STAGE_DEPTH];

  // Handshake outputs come from state alone, so out_ready never reaches in_ready.
  assign in_ready  = state_has_room(r_state);
  assign out_valid = state_has_entry(r_state);
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;
  assign w_clear   = reset | flush;

  always_comb begin
    w_state_next            = r_state;
    w_load[SLOT_MAIN]       = 1'b0;
    w_load[SLOT_SKID]       = 1'b0;
    w_main_from_skid        = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load[SLOT_MAIN] = 1'b1;
          w_state_next      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && w_deliver) begin
          w_load[SLOT_MAIN] = 1'b1;
        end else if (w_accept) begin
          w_load[SLOT_SKID] = 1'b1;
          w_state_next      = ST_FULL;
        end else if (w_deliver) begin
          w_state_next      = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_deliver) begin
          w_load[SLOT_MAIN] = 1'b1;
          w_main_from_skid  = 1'b1;
          w_state_next      = ST_ONE;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_d[SLOT_MAIN] = w_main_from_skid ? w_q[SLOT_SKID] : in_data;
  assign w_d[SLOT_SKID] = in_data;

  // Flush shares the storage reset path so both slots return to the bubble value.
  generate
    for (genvar gi = 0; gi < STAGE_DEPTH; gi++) begin : g_slot
      pipe_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_slot (
        .clk    (clk),
        .i_srst (w_clear),
        .i_load (w_load[gi]),
        .i_d    (w_d[gi]),
        .o_q    (w_q[gi])
      );
    end
  endgenerate

  assign out_data = w_q[SLOT_MAIN];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based occupancy model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_pipe_stage_reg;

  localparam int W = 32;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [C-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [W-1:0] m_q[$];
  logic [W-1:0] m_last = '0;
  int           m_cnt  = 0;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE('0), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: FIFO of at most two entries, popped on delivery, pushed on acceptance.
  always @(posedge clk) begin
    bit acc, del;
    if (reset) begin
      m_q.delete();
      m_last = '0;
      m_cnt  = 0;
    end else begin
      if (m_q.size() > 0 && !out_ready && m_cnt < (2**C - 1)) m_cnt++;
      if (flush) begin
        m_q.delete();
        m_last = '0;
      end else begin
        acc = in_valid && (m_q.size() < 2);
        del = (m_q.size() > 0) && out_ready;
        if (del) void'(m_q.pop_front());
        if (acc) m_q.push_back(in_data);
        if (m_q.size() > 0) m_last = m_q[0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
      check("model_in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < 2});
      check("model_out_data", out_data, m_last);
      check("model_stall_count", {28'd0, stall_count}, m_cnt);
    end
  end

  task automatic step(input logic rs, input logic fl, input logic iv,
                      input logic [W-1:0] d, input logic orr);
    reset = rs; flush = fl; in_valid = iv; in_data = d; out_ready = orr;
    @(posedge clk);
    #1;
    $display("txn t=%0t rst=%0b fl=%0b iv=%0b d=%08h or=%0b -> ov=%0b ir=%0b od=%08h sc=%0d",
             $time, rs, fl, iv, d, orr, out_valid, in_ready, out_data, stall_count);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    step(1, 0, 0, 32'h0, 0);
    chk_en = 1'b1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_data", out_data, 32'h0);
    check("reset_stall", {28'd0, stall_count}, 32'd0);

    step(0, 0, 1, 32'h11, 1); check("stream_0x11", out_data, 32'h11);
    check("stream_ready", {31'd0, in_ready}, 32'd1);
    step(0, 0, 1, 32'h22, 1); check("stream_0x22", out_data, 32'h22);
    step(0, 0, 1, 32'h33, 1); check("stream_0x33", out_data, 32'h33);
    check("stream_ready2", {31'd0, in_ready}, 32'd1);
    step(0, 0, 0, 32'h0, 1);
    check("empty_valid", {31'd0, out_valid}, 32'd0);
    check("empty_hold_data", out_data, 32'h33);

    step(0, 0, 1, 32'hA1, 0); check("bp_a1", out_data, 32'hA1);
    step(0, 0, 1, 32'hA2, 0); check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    step(0, 0, 1, 32'hA3, 0); check("bp_hold_a1", out_data, 32'hA1);
    step(0, 0, 1, 32'hA3, 1); check("bp_deliver_a2", out_data, 32'hA2);
    step(0, 0, 1, 32'hA3, 1); check("bp_deliver_a3", out_data, 32'hA3);
    step(0, 0, 0, 32'h0, 1);  check("bp_drained", {31'd0, out_valid}, 32'd0);

    step(0, 0, 1, 32'hC1, 0);
    step(0, 0, 1, 32'hC2, 0);
    check("pre_flush_full", {31'd0, in_ready}, 32'd0);
    step(0, 1, 1, 32'hB3, 0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_data", out_data, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    check("flush_no_b3", {31'd0, out_valid}, 32'd0);

    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'hD1, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 32'h0, 0);
      if (i == 10) check("stall_10", {28'd0, stall_count}, 32'd10);
    end
    check("stall_sat", {28'd0, stall_count}, 32'd15);
    step(0, 1, 0, 32'h0, 0);
    check("stall_flush_keep", {28'd0, stall_count}, 32'd15);

    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'hE1, 0);
    step(0, 0, 1, 32'hE2, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 0);
    check("pre_reset_stall", {28'd0, stall_count}, 32'd7);
    step(1, 0, 1, 32'hE3, 1);
    check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    check("mid_reset_data", out_data, 32'h0);
    check("mid_reset_stall", {28'd0, stall_count}, 32'd0);
    check("mid_reset_ready", {31'd0, in_ready}, 32'd1);
    step(0, 0, 1, 32'hF1, 1);
    check("post_reset_load", out_data, 32'hF1);

    for (int i = 0; i < 200; i++) begin
      step(0, ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
           32'h1000 + i, $urandom_range(0, 2) != 0);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits.
REQ-002 Parameter RESET_VALUE, default 0 (WIDTH bits): payload value loaded on reset or flush (bubble/NOP encoding).
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port flush, input, 1: synchronous discard of all held and incoming entries.
REQ-007 Port in_valid, input, 1: upstream entry present.
REQ-008 Port in_ready, output, 1: stage can accept an entry this cycle.
REQ-009 Port in_data, input, WIDTH: upstream payload.
REQ-010 Port out_valid, output, 1: entry presented downstream.
REQ-011 Port out_ready, input, 1: downstream accepts this cycle.
REQ-012 Port out_data, output, WIDTH: downstream payload.
REQ-013 Port stall_count, output, CNT_W: saturating count of output-stall cycles.

Function
REQ-014 Accept = in_valid & in_ready; deliver = out_valid & out_ready; both evaluated on the same edge.
REQ-015 Storage: main register (drives out_data) plus one skid register; two entries maximum.
REQ-016 States: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
REQ-017 out_valid = 1 in ONE and FULL, 0 in EMPTY.
REQ-018 in_ready = 1 in EMPTY and ONE, 0 in FULL; decoded from state only, never combinationally from out_ready.
REQ-019 EMPTY: accept -> main <= in_data, go ONE; otherwise stay.
REQ-020 ONE: accept & deliver -> main <= in_data, stay ONE; accept & !deliver -> skid <= in_data, go FULL; !accept & deliver -> go EMPTY; neither -> stay.
REQ-021 FULL: deliver -> main <= skid, go ONE; otherwise hold all.
REQ-022 Latency: accepted entry appears on out_data/out_valid the cycle after acceptance when the stage was EMPTY or delivering.
REQ-023 Entries leave in acceptance order; none duplicated or dropped except by flush/reset.
REQ-024 out_data holds the last main-register value while EMPTY; it changes only on load, skid transfer, flush or reset.
REQ-025 flush (reset low): state -> EMPTY, main and skid <= RESET_VALUE; a same-cycle accept is discarded; a same-cycle deliver completes normally downstream.
REQ-026 stall_count increments by 1 each cycle with out_valid & !out_ready; saturates at 2^CNT_W-1 (no wrap); unaffected by flush.

Reset
REQ-027 reset takes priority over flush and all handshakes.
REQ-028 On reset: state EMPTY, out_valid 0, in_ready 1, main and skid = RESET_VALUE (so out_data = RESET_VALUE), stall_count 0.
REQ-029 reset asserted mid-transfer discards both held entries; the first edge with reset low behaves as EMPTY.

Structure
REQ-030 The state enumeration (EMPTY, ONE, FULL) shall reside in the shared processor package, for reuse by other pipeline stages.
REQ-031 A sub-module pipe_data_reg (WIDTH-parametrised, synchronous active-high reset to a parametrised value, load enable) shall implement main and skid storage, instantiated twice.
REQ-032 No combinational path from out_ready to in_ready, or from in_data to out_data.

Verification (WIDTH=32, RESET_VALUE=0, CNT_W=4)
REQ-033 reset 1 cycle -> out_valid 0, in_ready 1, out_data 0x00000000, stall_count 0.
REQ-034 Streaming: out_ready=1, in_valid=1 with 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the following consecutive cycles, in_ready constantly 1.
REQ-035 Back-pressure: out_ready=0, push 0xA1 then 0xA2 -> FULL, in_ready 0, 0xA3 held off; raise out_ready -> 0xA1, 0xA2, 0xA3 delivered in order, none lost.
REQ-036 Flush in FULL with in_valid=1 (0xB3) -> next cycle out_valid 0, out_data 0x00000000, 0xB3 never delivered.
REQ-037 Stall saturation: one entry held, out_ready=0 for 20 cycles -> stall_count reaches 15 and stays 15.
REQ-038 reset asserted with FULL and stall_count 7 -> next cycle EMPTY, out_data 0, stall_count 0, in_ready 1.
